// File: rtl/game_state_manager.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_manager
//  Description : Game-rule FSM. Consumes single-hit collision pulses, tracks
//                lives, score, post-death invulnerability and the level-win
//                sequence; drives freeze/game_over to the sprite movers and
//                next_level/respawn back to the frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_state_manager #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned DEATH_FRAMES  = 45,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned WIN_FRAMES    = 90,
    parameter int unsigned BONUS_POINTS  = 100,
    parameter int unsigned GOAL_POINTS   = 1000,
    parameter int unsigned SCORE_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic               hit_hazard_a,
    input  logic               hit_hazard_b,
    input  logic               hit_goal,
    input  logic               hit_bonus,
    output logic [2:0]         state,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               freeze,
    output logic               invulnerable,
    output logic               next_level,
    output logic               respawn,
    output logic               game_over
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PLAY      = 3'd1;
    localparam logic [2:0] ST_DYING     = 3'd2;
    localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam int unsigned MAX_AB     = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int unsigned MAX_FRAMES = (MAX_AB > WIN_FRAMES) ? MAX_AB : WIN_FRAMES;
    localparam int unsigned TMR_W      = $clog2(MAX_FRAMES) + 1;
    // Wide enough that score + bonus + goal can never overflow before saturation.
    localparam int unsigned SUM_W      = SCORE_W + 34;

    localparam logic [TMR_W-1:0] DEATH_LAST  = TMR_W'(DEATH_FRAMES - 1);
    localparam logic [TMR_W-1:0] INVULN_LAST = TMR_W'(INVULN_FRAMES - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_FRAMES - 1);

    logic [2:0]         state_q,        state_d;
    logic [2:0]         lives_q,        lives_d;
    logic [SCORE_W-1:0] score_q,        score_d;
    logic [TMR_W-1:0]   timer_q,        timer_d;
    logic [TMR_W-1:0]   inv_tmr_q,      inv_tmr_d;
    logic               freeze_q,       freeze_d;
    logic               invulnerable_q, invulnerable_d;
    logic               next_level_q,   next_level_d;
    logic               respawn_q,      respawn_d;
    logic               game_over_q,    game_over_d;

    logic               hazard;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    // Saturating score update for the bonus/goal pulses of this clock.
    always_comb begin
        hazard    = hit_hazard_a | hit_hazard_b;
        score_sum = SUM_W'(score_q)
                  + (hit_bonus ? SUM_W'(BONUS_POINTS) : '0)
                  + (hit_goal  ? SUM_W'(GOAL_POINTS)  : '0);
        score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // Next-state logic for the game FSM, timers, lives and score.
    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        score_d        = score_q;
        timer_d        = timer_q;
        inv_tmr_d      = inv_tmr_q;
        invulnerable_d = invulnerable_q;
        next_level_d   = 1'b0;
        respawn_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_game) begin
                    state_d        = ST_PLAY;
                    lives_d        = 3'(LIVES_INIT);
                    score_d        = '0;
                    timer_d        = '0;
                    inv_tmr_d      = '0;
                    invulnerable_d = 1'b0;
                end
            end
            ST_PLAY: begin
                score_d = score_sat;
                // Immunity window only elapses while actually playing.
                if (invulnerable_q && startOfFrame) begin
                    if (inv_tmr_q == INVULN_LAST) begin
                        invulnerable_d = 1'b0;
                        inv_tmr_d      = '0;
                    end else begin
                        inv_tmr_d = inv_tmr_q + 1'b1;
                    end
                end
                // Reaching the goal wins over a coincident hazard.
                if (hit_goal) begin
                    state_d        = ST_LEVEL_UP;
                    timer_d        = '0;
                    invulnerable_d = 1'b0;
                    inv_tmr_d      = '0;
                end else if (hazard && !invulnerable_q) begin
                    state_d = ST_DYING;
                    timer_d = '0;
                    if (lives_q != 3'd0) begin
                        lives_d = lives_q - 3'd1;
                    end
                end
            end
            ST_DYING: begin
                if (startOfFrame) begin
                    if (timer_q == DEATH_LAST) begin
                        timer_d = '0;
                        if (lives_q == 3'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d        = ST_PLAY;
                            respawn_d      = 1'b1;
                            invulnerable_d = 1'b1;
                            inv_tmr_d      = '0;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_LEVEL_UP: begin
                if (startOfFrame) begin
                    if (timer_q == WIN_LAST) begin
                        timer_d      = '0;
                        state_d      = ST_PLAY;
                        next_level_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        freeze_d    = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    // State and output registers; reset aborts any sequence at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            lives_q        <= 3'(LIVES_INIT);
            score_q        <= '0;
            timer_q        <= '0;
            inv_tmr_q      <= '0;
            freeze_q       <= 1'b1;
            invulnerable_q <= 1'b0;
            next_level_q   <= 1'b0;
            respawn_q      <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            timer_q        <= timer_d;
            inv_tmr_q      <= inv_tmr_d;
            freeze_q       <= freeze_d;
            invulnerable_q <= invulnerable_d;
            next_level_q   <= next_level_d;
            respawn_q      <= respawn_d;
            game_over_q    <= game_over_d;
        end
    end

    assign state        = state_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign freeze       = freeze_q;
    assign invulnerable = invulnerable_q;
    assign next_level   = next_level_q;
    assign respawn      = respawn_q;
    assign game_over    = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_state_manager
//  Description : Directed self-checking bench for game_state_manager; a second
//                8-bit-score instance shares the stimulus to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_manager;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startOfFrame = 1'b0;
    logic start_game = 1'b0;
    logic hit_hazard_a = 1'b0;
    logic hit_hazard_b = 1'b0;
    logic hit_goal = 1'b0;
    logic hit_bonus = 1'b0;

    logic [2:0]  state, lives;
    logic [15:0] score;
    logic        freeze, invulnerable, next_level, respawn, game_over;

    logic [2:0]  state8, lives8;
    logic [7:0]  score8;
    logic        freeze8, invulnerable8, next_level8, respawn8, game_over8;

    int n_cmp = 0;
    int n_bad = 0;

    game_state_manager dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_game(start_game),
        .hit_hazard_a(hit_hazard_a), .hit_hazard_b(hit_hazard_b), .hit_goal(hit_goal),
        .hit_bonus(hit_bonus), .state(state), .lives(lives), .score(score),
        .freeze(freeze), .invulnerable(invulnerable), .next_level(next_level),
        .respawn(respawn), .game_over(game_over)
    );

    game_state_manager #(.SCORE_W(8)) dut8 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_game(start_game),
        .hit_hazard_a(hit_hazard_a), .hit_hazard_b(hit_hazard_b), .hit_goal(hit_goal),
        .hit_bonus(hit_bonus), .state(state8), .lives(lives8), .score(score8),
        .freeze(freeze8), .invulnerable(invulnerable8), .next_level(next_level8),
        .respawn(respawn8), .game_over(game_over8)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
        end
    endtask

    initial begin
        // Reset values
        step();
        step();
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_freeze", freeze, 1);
        check("rst_invuln", invulnerable, 0);
        check("rst_next_level", next_level, 0);
        check("rst_respawn", respawn, 0);
        check("rst_game_over", game_over, 0);
        reset = 1'b0;
        step();
        check("idle_hold", state, 0);

        // 1. start game
        start_game = 1'b1; step(); start_game = 1'b0;
        check("t1_state", state, 1);
        check("t1_lives", lives, 3);
        check("t1_score", score, 0);
        check("t1_freeze", freeze, 0);

        // 2. hazard -> DYING, 45 frames -> respawn
        hit_hazard_a = 1'b1; step(); hit_hazard_a = 1'b0;
        check("t2_state_dying", state, 2);
        check("t2_lives", lives, 2);
        check("t2_freeze", freeze, 1);
        frames(44);
        check("t2_still_dying", state, 2);
        check("t2_no_respawn_yet", respawn, 0);
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        check("t2_state_play", state, 1);
        check("t2_respawn", respawn, 1);
        check("t2_invuln", invulnerable, 1);
        check("t2_freeze", freeze, 0);
        step();
        check("t2_respawn_pulse", respawn, 0);

        // 3. invulnerable: hazard ignored; expires after 60 frames
        hit_hazard_b = 1'b1; step(); hit_hazard_b = 1'b0;
        check("t3_state_ignored", state, 1);
        check("t3_lives_kept", lives, 2);
        frames(59);
        check("t3_invuln_59", invulnerable, 1);
        frames(1);
        check("t3_invuln_60", invulnerable, 0);
        hit_hazard_a = 1'b1; step(); hit_hazard_a = 1'b0;
        check("t3_state_dying", state, 2);
        check("t3_lives", lives, 1);
        frames(45);
        check("t3_respawn_play", state, 1);
        check("t3_invuln_again", invulnerable, 1);

        // 4. goal + hazard + bonus -> LEVEL_UP, +1100
        hit_goal = 1'b1; hit_hazard_a = 1'b1; hit_bonus = 1'b1; step();
        hit_goal = 1'b0; hit_hazard_a = 1'b0; hit_bonus = 1'b0;
        check("t4_state", state, 3);
        check("t4_score", score, 1100);
        check("t4_lives", lives, 1);
        check("t4_invuln_cleared", invulnerable, 0);
        check("t4_freeze", freeze, 1);
        check("t4_score8_sat", score8, 255);
        hit_bonus = 1'b1; hit_hazard_b = 1'b1; step(); hit_bonus = 1'b0; hit_hazard_b = 1'b0;
        check("t4_bonus_ignored", score, 1100);
        check("t4_hazard_ignored", lives, 1);
        frames(89);
        check("t4_still_level_up", state, 3);
        check("t4_no_next_level", next_level, 0);
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        check("t4_state_play", state, 1);
        check("t4_next_level", next_level, 1);
        check("t4_lives_kept", lives, 1);
        step();
        check("t4_next_level_pulse", next_level, 0);

        // 5. last life -> GAME_OVER -> restart
        hit_hazard_a = 1'b1; step(); hit_hazard_a = 1'b0;
        check("t5_state_dying", state, 2);
        check("t5_lives", lives, 0);
        frames(44);
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        check("t5_state_over", state, 4);
        check("t5_game_over", game_over, 1);
        check("t5_freeze", freeze, 1);
        check("t5_no_respawn", respawn, 0);
        hit_bonus = 1'b1; step(); hit_bonus = 1'b0;
        check("t5_bonus_ignored", score, 1100);
        start_game = 1'b1; step(); start_game = 1'b0;
        check("t5_restart_state", state, 1);
        check("t5_restart_lives", lives, 3);
        check("t5_restart_score", score, 0);
        check("t5_game_over_clr", game_over, 0);

        // 6. 8-bit score saturation, then reset inside DYING
        hit_bonus = 1'b1; step(); hit_bonus = 1'b0;
        check("t6_score8_100", score8, 100);
        hit_bonus = 1'b1; step(); hit_bonus = 1'b0;
        check("t6_score8_200", score8, 200);
        hit_bonus = 1'b1; step(); hit_bonus = 1'b0;
        check("t6_score8_sat", score8, 255);
        hit_bonus = 1'b1; step(); hit_bonus = 1'b0;
        check("t6_score8_held", score8, 255);
        check("t6_score16", score, 400);
        hit_hazard_a = 1'b1; step(); hit_hazard_a = 1'b0;
        check("t6_state_dying", state, 2);
        frames(10);
        reset = 1'b1;
        #1;
        check("t6_rst_state", state, 0);
        check("t6_rst_lives", lives, 3);
        check("t6_rst_score", score, 0);
        check("t6_rst_score8", score8, 0);
        check("t6_rst_freeze", freeze, 1);
        check("t6_rst_invuln", invulnerable, 0);
        check("t6_rst_respawn", respawn, 0);
        check("t6_rst_game_over", game_over, 0);
        step();
        reset = 1'b0;
        step();
        check("t6_idle_after_rst", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
